// File: rtl/ps2_pkg.sv
// Shared constants, frame state encoding and parity helper for the PS/2 transmitter hub.
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_D0     = 4'd1,
    ST_D1     = 4'd2,
    ST_D2     = 4'd3,
    ST_D3     = 4'd4,
    ST_D4     = 4'd5,
    ST_D5     = 4'd6,
    ST_D6     = 4'd7,
    ST_D7     = 4'd8,
    ST_PARITY = 4'd9,
    ST_STOP   = 4'd10,
    ST_END    = 4'd11
  } tx_state_t;

  // Running odd-parity accumulator: seeded with 1, folded with every data bit sent.
  function automatic logic par_step(input logic par, input logic bit_in);
    return par ^ bit_in;
  endfunction

endpackage

// File: rtl/ps2_tx_chan.sv
// One PS/2 transmit channel: byte FIFO, inhibit synchroniser and frame FSM driven by the shared tick.
module ps2_tx_chan
  import ps2_pkg::*;
#(
  parameter int FIFO_BITS = 3
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic                     clk_ps2,
  input  logic                     wr,
  input  logic [PS2_DATA_BITS-1:0] wr_data,
  input  logic                     ovf_clr,
  input  logic                     host_inhibit,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic                     busy,
  output logic                     ps2_clk,
  output logic                     ps2_data
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0]   DEPTH_C = (FIFO_BITS + 1)'(DEPTH);
  localparam logic [FIFO_BITS:0]   CNT_ONE = (FIFO_BITS + 1)'(1);
  localparam logic [FIFO_BITS-1:0] PTR_ONE = FIFO_BITS'(1);

  logic [PS2_DATA_BITS-1:0] mem_r [DEPTH];
  logic [FIFO_BITS-1:0]     wr_ptr_r, rd_ptr_r;
  logic [FIFO_BITS:0]       cnt_r, cnt_s;
  logic                     full_r, ovf_r;
  logic [1:0]               sync_r;
  tx_state_t                state_r, state_s;
  logic [PS2_DATA_BITS-1:0] shift_r, shift_s;
  logic                     par_r, par_s, data_r, data_s;
  logic                     pop_s, acc_s, inh_s, empty_s;

  assign inh_s   = sync_r[1];
  assign empty_s = (cnt_r == '0);
  // A pop frees a slot in the same cycle, so a write to a full FIFO is still taken then.
  assign acc_s   = wr & (~full_r | pop_s);

  // Next FIFO occupancy from accepted write and pop.
  always_comb begin
    cnt_s = cnt_r;
    if (acc_s && !pop_s) begin
      cnt_s = cnt_r + CNT_ONE;
    end else if (pop_s && !acc_s) begin
      cnt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_sys) begin
    if (acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers, occupancy, full/overflow flags and inhibit synchroniser.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
      sync_r   <= 2'b00;
    end else begin
      if (acc_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      cnt_r  <= cnt_s;
      full_r <= (cnt_s == DEPTH_C);
      if (wr && !acc_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end
      sync_r <= {sync_r[0], host_inhibit};
    end
  end

  // Frame sequencing; an inhibit abort overrides tick and leaves the byte queued for resend.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    par_s   = par_r;
    data_s  = data_r;
    pop_s   = 1'b0;
    if (inh_s && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
      data_s  = 1'b1;
    end else if (tick) begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s && !inh_s) begin
            shift_s = mem_r[rd_ptr_r];
            par_s   = 1'b1;
            data_s  = 1'b0;
            state_s = ST_D0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_D0, ST_D1, ST_D2, ST_D3, ST_D4, ST_D5, ST_D6, ST_D7: begin
          data_s  = shift_r[0];
          shift_s = {1'b0, shift_r[PS2_DATA_BITS-1:1]};
          par_s   = par_step(par_r, shift_r[0]);
          state_s = tx_state_t'(state_r + 4'd1);
        end
        ST_PARITY: begin
          data_s  = par_r;
          state_s = ST_STOP;
        end
        ST_STOP: begin
          data_s  = 1'b1;
          state_s = ST_END;
        end
        ST_END: begin
          pop_s   = 1'b1;
          data_s  = 1'b1;
          state_s = ST_IDLE;
        end
        default: begin
          data_s  = 1'b1;
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Frame state and registered data line.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      shift_r <= '0;
      par_r   <= 1'b0;
      data_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      par_r   <= par_s;
      data_r  <= data_s;
    end
  end

  assign busy      = (state_r != ST_IDLE);
  assign ps2_clk   = clk_ps2 | ~busy;
  assign ps2_data  = data_r;
  assign fifo_full = full_r;
  assign overflow  = ovf_r;

endmodule

// File: rtl/ps2_tx_hub.sv
// Multi-channel PS/2 device-side transmitter: shared clock divider feeding CHANNELS independent channels.
module ps2_tx_hub
  import ps2_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 100
) (
  input  logic                              clk_sys,
  input  logic                              reset_n,
  input  logic [CHANNELS-1:0]               wr,
  input  logic [PS2_DATA_BITS*CHANNELS-1:0] wr_data,
  input  logic [CHANNELS-1:0]               ovf_clr,
  input  logic [CHANNELS-1:0]               host_inhibit,
  output logic [CHANNELS-1:0]               fifo_full,
  output logic [CHANNELS-1:0]               overflow,
  output logic [CHANNELS-1:0]               busy,
  output logic [CHANNELS-1:0]               ps2_clk,
  output logic [CHANNELS-1:0]               ps2_data
);

  localparam int DW = (PS2DIV < 1) ? 1 : $clog2(PS2DIV + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(PS2DIV);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);

  logic [DW-1:0] div_cnt_r;
  logic          clk_ps2_r;
  logic          tick_r;

  // Shared divider; tick is high during the first cycle clk_ps2 is high.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      div_cnt_r <= '0;
      clk_ps2_r <= 1'b0;
      tick_r    <= 1'b0;
    end else if (div_cnt_r == DIV_MAX) begin
      div_cnt_r <= '0;
      clk_ps2_r <= ~clk_ps2_r;
      tick_r    <= ~clk_ps2_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
      tick_r    <= 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    ps2_tx_chan #(
      .FIFO_BITS(FIFO_BITS)
    ) u_chan (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .tick         (tick_r),
      .clk_ps2      (clk_ps2_r),
      .wr           (wr[g]),
      .wr_data      (wr_data[PS2_DATA_BITS*g +: PS2_DATA_BITS]),
      .ovf_clr      (ovf_clr[g]),
      .host_inhibit (host_inhibit[g]),
      .fifo_full    (fifo_full[g]),
      .overflow     (overflow[g]),
      .busy         (busy[g]),
      .ps2_clk      (ps2_clk[g]),
      .ps2_data     (ps2_data[g])
    );
  end

endmodule

// File: tb/tb_ps2_tx_hub.sv
// Self-checking bench for ps2_tx_hub: decodes PS/2 frames on ps2_clk falling edges and checks them.
module tb_ps2_tx_hub;

  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [1:0]  wr, ovf_clr, host_inhibit;
  logic [15:0] wr_data;
  logic [1:0]  fifo_full, overflow, busy, ps2_clk, ps2_data;

  int checks = 0;
  int failures = 0;

  ps2_tx_hub #(.CHANNELS(2), .FIFO_BITS(3), .PS2DIV(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .wr(wr), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .host_inhibit(host_inhibit), .fifo_full(fifo_full),
    .overflow(overflow), .busy(busy), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (bit k = k-th sampled bit).
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~(^b), b, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Host-side receiver: a frame counts only if busy drops after exactly 11 clock falls.
  logic [10:0] rx0[$], rx1[$];
  logic [10:0] sh [2];
  int          bc [2];
  logic        pclk_q [2];
  logic        busy_q [2];

  initial begin
    for (int c = 0; c < 2; c++) begin
      bc[c] = 0; pclk_q[c] = 1'b1; busy_q[c] = 1'b0; sh[c] = '0;
    end
  end

  always @(negedge clk_sys) begin
    for (int c = 0; c < 2; c++) begin
      if (pclk_q[c] === 1'b1 && ps2_clk[c] === 1'b0) begin
        if (bc[c] < 11) sh[c][bc[c]] = ps2_data[c];
        bc[c]++;
      end
      if (busy_q[c] === 1'b1 && busy[c] === 1'b0) begin
        if (bc[c] == 11) begin
          if (c == 0) rx0.push_back(sh[c]);
          else        rx1.push_back(sh[c]);
        end
        bc[c] = 0;
      end
      pclk_q[c] = ps2_clk[c];
      busy_q[c] = busy[c];
    end
  end

  function automatic int qsize(input int c);
    return (c == 0) ? rx0.size() : rx1.size();
  endfunction

  task automatic wait_frames(input int c, input int n);
    int k;
    k = 0;
    while (qsize(c) < n && k < 200 * n + 400) begin
      @(negedge clk_sys);
      k++;
    end
    check($sformatf("frame_count_ch%0d", c), qsize(c), n);
  endtask

  task automatic wait_bits(input int c, input int n);
    int k;
    k = 0;
    while (bc[c] < n && k < 400) begin
      @(negedge clk_sys);
      k++;
    end
    check($sformatf("reach_bit%0d_ch%0d", n, c), (bc[c] >= n), 1);
  endtask

  task automatic put(input int c, input logic [7:0] b);
    @(negedge clk_sys);
    wr = '0; wr[c] = 1'b1; wr_data[8*c +: 8] = b;
    @(negedge clk_sys);
    wr = '0;
  endtask

  typedef struct {
    int          ch;
    logic [7:0]  b;
    logic [10:0] frame;
  } vec_t;

  vec_t vt[6];

  logic [7:0] eq0[$], eq1[$];
  int         mcnt [2];
  logic       bq [2];
  int         sent;
  bit         quiet_bad, idle_bad;
  int         k;

  initial begin
    vt[0] = '{0, 8'h1C, 11'h438};
    vt[1] = '{0, 8'h00, 11'h600};
    vt[2] = '{1, 8'hFF, 11'h7FE};
    vt[3] = '{1, 8'h80, 11'h500};
    vt[4] = '{0, 8'hA5, 11'h74A};
    vt[5] = '{1, 8'h01, 11'h402};

    reset_n = 1'b0; wr = '0; wr_data = '0; ovf_clr = '0; host_inhibit = '0;
    repeat (5) @(negedge clk_sys);
    check("rst_ps2_data", ps2_data, 2'b11);
    check("rst_ps2_clk", ps2_clk, 2'b11);
    check("rst_busy", busy, 2'b00);
    check("rst_fifo_full", fifo_full, 2'b00);
    check("rst_overflow", overflow, 2'b00);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Single-byte frames from the table; the other channel must stay idle-high.
    for (int i = 0; i < 6; i++) begin
      rx0.delete(); rx1.delete();
      quiet_bad = 1'b0;
      put(vt[i].ch, vt[i].b);
      k = 0;
      while (qsize(vt[i].ch) < 1 && k < 600) begin
        @(negedge clk_sys);
        k++;
        if (ps2_clk[1-vt[i].ch] !== 1'b1 || ps2_data[1-vt[i].ch] !== 1'b1) quiet_bad = 1'b1;
      end
      check($sformatf("vec%0d_count", i), qsize(vt[i].ch), 1);
      if (vt[i].ch == 0) check($sformatf("vec%0d_frame", i), (rx0.size() > 0) ? rx0[0] : 11'h0, vt[i].frame);
      else               check($sformatf("vec%0d_frame", i), (rx1.size() > 0) ? rx1[0] : 11'h0, vt[i].frame);
      check($sformatf("vec%0d_other_idle", i), quiet_bad, 1'b0);
      check($sformatf("vec%0d_other_count", i), qsize(1 - vt[i].ch), 0);
    end

    // Overflow: nine back-to-back writes into an eight-deep FIFO.
    rx0.delete(); rx1.delete();
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk_sys);
      wr = 2'b01; wr_data[7:0] = 8'(i);
    end
    @(negedge clk_sys);
    wr = '0;
    check("ovf_full", fifo_full, 2'b01);
    check("ovf_flag", overflow, 2'b01);
    wait_frames(0, 8);
    for (int i = 0; i < 8 && i < rx0.size(); i++)
      check($sformatf("ovf_frame%0d", i), rx0[i], frame_of(8'(i + 1)));
    repeat (300) @(negedge clk_sys);
    check("ovf_no_ninth", rx0.size(), 8);
    check("ovf_full_drained", fifo_full, 2'b00);
    check("ovf_sticky", overflow, 2'b01);
    ovf_clr = 2'b01;
    @(negedge clk_sys);
    ovf_clr = '0;
    @(negedge clk_sys);
    check("ovf_cleared", overflow, 2'b00);

    // Inhibit abort in data bit 4 of 0xA5, then full retransmission.
    rx0.delete();
    put(0, 8'hA5);
    wait_bits(0, 5);
    repeat (7) @(negedge clk_sys);
    host_inhibit = 2'b01;
    repeat (3) @(negedge clk_sys);
    check("inh_data", ps2_data[0], 1'b1);
    check("inh_clk", ps2_clk[0], 1'b1);
    check("inh_busy", busy[0], 1'b0);
    idle_bad = 1'b0;
    repeat (60) begin
      @(negedge clk_sys);
      if (busy[0] !== 1'b0 || ps2_clk[0] !== 1'b1) idle_bad = 1'b1;
    end
    check("inh_hold_idle", idle_bad, 1'b0);
    check("inh_partial_dropped", rx0.size(), 0);
    host_inhibit = '0;
    wait_frames(0, 1);
    check("inh_retx_frame", (rx0.size() > 0) ? rx0[0] : 11'h0, 11'h74A);
    repeat (300) @(negedge clk_sys);
    check("inh_fifo_empty", rx0.size(), 1);
    check("inh_busy_after", busy[0], 1'b0);

    // Parallel channels: same-cycle writes start on the same tick.
    rx0.delete(); rx1.delete();
    @(negedge clk_sys);
    wr = 2'b11; wr_data = {8'hF0, 8'h12};
    @(negedge clk_sys);
    wr = '0;
    k = 0;
    while (busy == 2'b00 && k < 100) begin
      @(negedge clk_sys);
      k++;
    end
    check("par_start_together", busy, 2'b11);
    wait_frames(0, 1);
    wait_frames(1, 1);
    check("par_frame_ch0", (rx0.size() > 0) ? rx0[0] : 11'h0, 11'h624);
    check("par_frame_ch1", (rx1.size() > 0) ? rx1[0] : 11'h0, 11'h7E0);

    // Random traffic against a queue model; writes only while the model has room.
    rx0.delete(); rx1.delete(); eq0.delete(); eq1.delete();
    mcnt[0] = 0; mcnt[1] = 0; bq[0] = busy[0]; bq[1] = busy[1]; sent = 0;
    while (sent < 40) begin
      @(negedge clk_sys);
      for (int c = 0; c < 2; c++) begin
        if (bq[c] && !busy[c]) mcnt[c]--;
        if (wr[c]) mcnt[c]++;
        bq[c] = busy[c];
        check($sformatf("rnd_full_ch%0d", c), fifo_full[c], (mcnt[c] == DEPTH));
      end
      wr = '0;
      for (int c = 0; c < 2; c++) begin
        if (sent < 40 && mcnt[c] < DEPTH && $urandom_range(0, 3) == 0) begin
          logic [7:0] b;
          b = 8'($urandom);
          wr[c] = 1'b1;
          wr_data[8*c +: 8] = b;
          if (c == 0) eq0.push_back(b);
          else        eq1.push_back(b);
          sent++;
        end
      end
    end
    @(negedge clk_sys);
    wr = '0;
    wait_frames(0, eq0.size());
    wait_frames(1, eq1.size());
    for (int i = 0; i < eq0.size() && i < rx0.size(); i++)
      check($sformatf("rnd_ch0_frame%0d", i), rx0[i], frame_of(eq0[i]));
    for (int i = 0; i < eq1.size() && i < rx1.size(); i++)
      check($sformatf("rnd_ch1_frame%0d", i), rx1[i], frame_of(eq1[i]));
    check("rnd_overflow", overflow, 2'b00);

    // Reset during the parity bit with two bytes still queued.
    rx0.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      wr = 2'b01; wr_data[7:0] = 8'h11 * 8'(i + 1);
    end
    @(negedge clk_sys);
    wr = '0;
    wait_bits(0, 10);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check("rstmid_data", ps2_data, 2'b11);
    check("rstmid_clk", ps2_clk, 2'b11);
    check("rstmid_full", fifo_full, 2'b00);
    check("rstmid_busy", busy, 2'b00);
    @(negedge clk_sys);
    reset_n = 1'b1;
    idle_bad = 1'b0;
    repeat (400) begin
      @(negedge clk_sys);
      if (busy !== 2'b00) idle_bad = 1'b1;
    end
    check("rstmid_stays_idle", idle_bad, 1'b0);
    check("rstmid_no_frames", rx0.size(), 0);
    put(0, 8'h01);
    wait_frames(0, 1);
    check("rstmid_new_frame", (rx0.size() > 0) ? rx0[0] : 11'h0, 11'h402);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_tx_hub.md
# ps2_tx_hub

Parametrised multi-channel PS/2 device-side transmitter for the MiST I/O path. It generalises the fixed keyboard/mouse transmitter pair to CHANNELS independent channels, each with its own FIFO of 2^FIFO_BITS bytes, sharing one PS/2 clock divider. New behaviour over the fixed pair:

- host-inhibit abort, with retransmission of the interrupted byte;
- FIFO full and sticky overflow reporting;
- synchronous reset.

It sits between the SPI command decoder (byte producer) and the core's PS/2 controllers.

## Interface
Parameters:
- CHANNELS, 2, number of independent PS/2 channels (1..8)
- FIFO_BITS, 3, log2 FIFO depth per channel (depth 8 by default)
- PS2DIV, 100, divider; clk_ps2 period = 2*(PS2DIV+1) clk_sys cycles

Ports:
- clk_sys  in  1  system clock; everything on posedge
- reset_n  in  1  reset, synchronous, active-low
- wr  in  CHANNELS  per-channel byte write strobe, one cycle per byte
- wr_data  in  8*CHANNELS  byte for channel i at [8*i+:8]
- ovf_clr  in  CHANNELS  clears overflow[i]
- host_inhibit  in  CHANNELS  asynchronous; host holding PS/2 clock low
- fifo_full  out  CHANNELS  FIFO i holds 2^FIFO_BITS bytes
- overflow  out  CHANNELS  sticky; a write to a full FIFO was dropped
- busy  out  CHANNELS  frame in progress
- ps2_clk  out  CHANNELS  emulated PS/2 clock
- ps2_data  out  CHANNELS  emulated PS/2 data

## Operation
- **Divider:** a counter 0..PS2DIV toggles clk_ps2 when the count equals PS2DIV, then wraps to 0. `tick` is a one-cycle pulse on the cycle clk_ps2 goes 0→1. The divider and tick are shared by all channels.
- **FIFO per channel:** circular buffer with a count of 0..2^FIFO_BITS.
  - A write is accepted if not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - ovf_clr clears overflow. Set has priority if a drop and ovf_clr coincide.
- **Inhibit input:** host_inhibit passes through a 2-FF synchroniser; call the result inh.
- **FSM per channel**, tx_state 0..11, advancing only on tick:
  - IDLE (0): if the FIFO is not empty and inh=0, load the head byte into the shift register, set parity=1, set data=0 (start bit), go to 1. The byte is not popped here.
  - DATA (1..8): data = shift[0], shift right, toggle parity if the bit is 1. Data is sent LSB first.
  - PARITY (9): data = parity (odd parity).
  - STOP (10): data = 1.
  - END (11): pop the FIFO, go to 0.
- **Inhibit abort:** inh=1 with tx_state≠0 aborts on any cycle, not only on tick.
  - tx_state←0, data←1, no pop.
  - The same byte is retransmitted from the start bit once inh=0.
  - While inh=1 and idle, no frame starts.
- **Outputs:**
  - busy = (tx_state≠0).
  - ps2_clk = clk_ps2 | ~busy.
  - ps2_data is registered.
- **Reset (reset_n=0):**
  - Divider count 0 and clk_ps2=0.
  - All FIFOs emptied; tx_state=0; synchronisers cleared.
  - ps2_data=1, ps2_clk=1, busy=0, fifo_full=0, overflow=0.
  - Reset mid-frame abandons the frame; the byte is lost.

## Timing
- Data changes on the cycle after tick, while clk_ps2 is high; the host samples on the clk_ps2 falling edge.
- Frame = 11 bits (start, 8 data, parity, stop), plus one END tick period with the line high. Total 12 tick periods of 2*(PS2DIV+1) cycles each.
- Write-to-start latency: write at cycle t is visible in the FIFO at t+1. The start bit drives on the first tick at or after t+1, plus 1 cycle. The worst case is one tick period + 2 cycles.
- Back-to-back bytes: the next start bit drives on the tick after END, so there is one idle-high tick period between frames.
- Abort latency: host_inhibit rise → ps2_data=1 and ps2_clk=1 within 3 clk_sys cycles (2 sync + 1 register).
- fifo_full and overflow are registered and update one cycle after the causing write or pop.

## Structure
- Package ps2_pkg holds:
  - state constants ST_IDLE=0, ST_PARITY=9, ST_STOP=10, ST_END=11;
  - PS2_DATA_BITS=8.
- Sub-module ps2_tx_chan: FIFO, synchroniser and FSM for one channel. It takes tick and clk_ps2 as inputs and is generated CHANNELS times.
- The top level holds the divider and the bus slicing.

## Test plan
- **Byte 0x1C:** PS2DIV=4; write 0x1C on ch0. Sampled on clk_ps2 falling edges, ps2_data shows 0,0,0,1,1,1,0,0,0,0(parity),1. busy drops after END. ch1 stays idle-high.
- **Byte 0x00:** write 0x00. Data bits are all 0, parity bit=1, stop=1.
- **Overflow:** with FIFO_BITS=3, write 9 bytes 0x01..0x09 in consecutive cycles.
  - fifo_full=1 and overflow=1.
  - Frames 0x01..0x08 are emitted in order; 0x09 is never emitted.
  - ovf_clr → overflow=0.
- **Inhibit abort:** assert host_inhibit during data bit 4 of 0xA5.
  - Within 3 cycles ps2_data=1, ps2_clk=1, busy=0.
  - Release → 0xA5 is retransmitted in full, then the FIFO is empty.
- **Parallel channels:** write 0x12 on ch0 and 0xF0 on ch1 in the same cycle. Both frames start on the same tick and complete independently with correct parity.
- **Reset mid-frame:** reset_n low during the parity bit with 2 bytes queued.
  - Next cycle ps2_data=1, ps2_clk=1, fifo_full=0.
  - After release, no frame is sent until a new write.
